// File: rtl/video_timing_gen.sv
// ============================================================================
// video_timing_gen
// ----------------------------------------------------------------------------
// Single-clock raster generator in the pixel domain.
//
// The block runs free-running horizontal and vertical counters. From them it
// decodes a pixel request stream, with x/y coordinates, for the frame-buffer
// fetch logic. It also drives a registered VGA-style hsync/vsync/blank/RGB444
// stream for the HDMI/DVI encoder. Pixel data from the fetch path arrives
// PIXEL_LATENCY cycles after its request. The decoded sync and blank bits are
// delayed by the same amount, so every output bit leaves the output register
// PIXEL_LATENCY+1 cycles after the counter state that produced it.
//
// Optional feature (compile-time macro VTG_TEST_PATTERN_EN):
//   When the macro is defined, the design has an extra input test_pattern_i.
//   While it is high, the colour output shows 8 vertical colour bars instead
//   of r_i/g_i/b_i. The bars are indexed by the delayed x, and blank masking
//   still applies.
//
// Ports:
//   clk_pixel        in   pixel clock (the only clock)
//   reset_i          in   asynchronous, active-high reset
//   req_o            out  pixel request, high inside the active area
//   x_o / y_o        out  horizontal / vertical counter (11 / 10 bits)
//   line_start_o     out  pulse at h_cnt==0 on active lines
//   frame_start_o    out  pulse at h_cnt==0, v_cnt==0
//   r_i, g_i, b_i    in   4-bit pixel data, PIXEL_LATENCY cycles after request
//   test_pattern_i   in   colour-bar select (only with VTG_TEST_PATTERN_EN)
//   vga_hsync_o      out  registered hsync, polarity set by H_SYNC_POL
//   vga_vsync_o      out  registered vsync, polarity set by V_SYNC_POL
//   vga_blank_o      out  registered blank, high outside the active area
//   vga_r_o/g_o/b_o  out  registered 4-bit colour, zero while blanked
// ============================================================================
module video_timing_gen #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter bit H_SYNC_POL    = 1'b0,
    parameter bit V_SYNC_POL    = 1'b0,
    parameter int PIXEL_LATENCY = 2
) (
    input  logic        clk_pixel,
    input  logic        reset_i,
    output logic        req_o,
    output logic [10:0] x_o,
    output logic [9:0]  y_o,
    output logic        line_start_o,
    output logic        frame_start_o,
    input  logic [3:0]  r_i,
    input  logic [3:0]  g_i,
    input  logic [3:0]  b_i,
`ifdef VTG_TEST_PATTERN_EN
    input  logic        test_pattern_i,
`endif
    output logic        vga_hsync_o,
    output logic        vga_vsync_o,
    output logic        vga_blank_o,
    output logic [3:0]  vga_r_o,
    output logic [3:0]  vga_g_o,
    output logic [3:0]  vga_b_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode thresholds are one bit wider than the counters. A sync end
    // that lands exactly on 2048/1024 therefore does not wrap to zero.
    localparam logic [11:0] H_ACT_X   = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_SX = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_EX = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_X   = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_SX = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_EX = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);

    // Configuration errors are caught at elaboration.
    if (H_TOTAL > 2048) begin : g_h_total_err
        $error("video_timing_gen: H_TOTAL %0d exceeds 2048", H_TOTAL);
    end
    if (V_TOTAL > 1024) begin : g_v_total_err
        $error("video_timing_gen: V_TOTAL %0d exceeds 1024", V_TOTAL);
    end
    if (PIXEL_LATENCY < 1 || PIXEL_LATENCY > 4) begin : g_lat_err
        $error("video_timing_gen: PIXEL_LATENCY %0d outside 1..4", PIXEL_LATENCY);
    end

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic [11:0] h_ext;
    logic [10:0] v_ext;
    logic        active;
    logic        hs;
    logic        vs;

    // ---- p0: raster counters and per-cycle decode ----
    always_ff @(posedge clk_pixel or posedge reset_i) begin
        if (reset_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign h_ext  = {1'b0, h_cnt};
    assign v_ext  = {1'b0, v_cnt};
    assign active = (h_ext < H_ACT_X) && (v_ext < V_ACT_X);
    assign hs     = (h_ext >= H_SYNC_SX) && (h_ext < H_SYNC_EX);
    assign vs     = (v_ext >= V_SYNC_SX) && (v_ext < V_SYNC_EX);

    assign x_o           = h_cnt;
    assign y_o           = v_cnt;
    assign req_o         = active;
    assign line_start_o  = (h_cnt == '0) && (v_ext < V_ACT_X);
    assign frame_start_o = (h_cnt == '0) && (v_cnt == '0);

    // ---- p1..pN: delay line matching the fetch latency ----
    // The sync bits are stored in their asserted sense, so the reset value 0
    // means inactive, whatever polarity is chosen.
    logic hs_p    [PIXEL_LATENCY];
    logic vs_p    [PIXEL_LATENCY];
    logic blank_p [PIXEL_LATENCY];

    always_ff @(posedge clk_pixel or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < PIXEL_LATENCY; i++) begin
                hs_p[i]    <= 1'b0;
                vs_p[i]    <= 1'b0;
                blank_p[i] <= 1'b1;
            end
        end else begin
            hs_p[0]    <= hs;
            vs_p[0]    <= vs;
            blank_p[0] <= ~active;
            for (int i = 1; i < PIXEL_LATENCY; i++) begin
                hs_p[i]    <= hs_p[i-1];
                vs_p[i]    <= vs_p[i-1];
                blank_p[i] <= blank_p[i-1];
            end
        end
    end

    logic        hs_d;
    logic        vs_d;
    logic        blank_d;
    logic [11:0] pix_rgb;

    assign hs_d    = hs_p[PIXEL_LATENCY-1];
    assign vs_d    = vs_p[PIXEL_LATENCY-1];
    assign blank_d = blank_p[PIXEL_LATENCY-1];

`ifdef VTG_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

    if (H_ACTIVE < 8) begin : g_bar_err
        $error("video_timing_gen: H_ACTIVE %0d too small for 8 colour bars", H_ACTIVE);
    end

    // x travels with the sync/blank bits. It is masked by blank downstream,
    // so it does not need a reset.
    logic [10:0] x_p [PIXEL_LATENCY];

    always_ff @(posedge clk_pixel) begin
        x_p[0] <= h_cnt;
        for (int i = 1; i < PIXEL_LATENCY; i++) begin
            x_p[i] <= x_p[i-1];
        end
    end

    // Bar index from x. Any remainder pixels when H_ACTIVE is not a multiple
    // of 8 are clamped into the last bar.
    function automatic logic [2:0] bar_index(input logic [10:0] x);
        logic [10:0] q;
        q = x / BAR_W;
        return (q > 11'd7) ? 3'd7 : q[2:0];
    endfunction

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = 12'hFFF;
            3'd1:    c = 12'hFF0;
            3'd2:    c = 12'h0FF;
            3'd3:    c = 12'h0F0;
            3'd4:    c = 12'hF0F;
            3'd5:    c = 12'hF00;
            3'd6:    c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    always_comb begin
        pix_rgb = '0;
        if (!blank_d) begin
            if (test_pattern_i) pix_rgb = bar_colour(bar_index(x_p[PIXEL_LATENCY-1]));
            else                pix_rgb = {r_i, g_i, b_i};
        end
    end
`else
    always_comb begin
        pix_rgb = '0;
        if (!blank_d) pix_rgb = {r_i, g_i, b_i};
    end
`endif

    // ---- output register: realigned sync/blank/colour ----
    always_ff @(posedge clk_pixel or posedge reset_i) begin
        if (reset_i) begin
            vga_hsync_o <= ~H_SYNC_POL;
            vga_vsync_o <= ~V_SYNC_POL;
            vga_blank_o <= 1'b1;
            vga_r_o     <= '0;
            vga_g_o     <= '0;
            vga_b_o     <= '0;
        end else begin
            vga_hsync_o <= hs_d ^ ~H_SYNC_POL;
            vga_vsync_o <= vs_d ^ ~V_SYNC_POL;
            vga_blank_o <= blank_d;
            vga_r_o     <= pix_rgb[11:8];
            vga_g_o     <= pix_rgb[7:4];
            vga_b_o     <= pix_rgb[3:0];
        end
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Single-clock raster generator in the pixel domain. It produces horizontal and vertical counters, the pixel request stream with x/y coordinates for the frame-buffer fetch logic, and the registered VGA-style hsync/vsync/blank/RGB444 output that feeds the HDMI/DVI encoder. The RGB returned by the upstream fetch path arrives after a fixed latency and is realigned with sync and blank, so the encoder sees a coherent pixel stream.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync and back porch in lines
- H_SYNC_POL / V_SYNC_POL, 0 / 0, active level of hsync and vsync (0 means active-low)
- PIXEL_LATENCY, 2, cycles from `req_o` to valid `r_i/g_i/b_i`; legal range 1..4
- clk_pixel  in  1  pixel clock; the only clock
- reset_i  in  1  asynchronous, active-high reset
- req_o  out  1  pixel request; high while the counters are inside the active area
- x_o  out  11  current horizontal count (h_cnt)
- y_o  out  10  current vertical count (v_cnt)
- line_start_o  out  1  one-cycle pulse at h_cnt==0 for v_cnt<V_ACTIVE
- frame_start_o  out  1  one-cycle pulse at h_cnt==0 and v_cnt==0
- r_i, g_i, b_i  in  4 each  pixel data, valid PIXEL_LATENCY cycles after its request
- vga_hsync_o, vga_vsync_o  out  1 each  registered syncs
- vga_blank_o  out  1  registered blank; high outside the active area
- vga_r_o, vga_g_o, vga_b_o  out  4 each  registered pixel colour

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way.
- h_cnt increments every cycle and wraps from H_TOTAL-1 to 0. When h_cnt wraps, v_cnt increments; v_cnt wraps from V_TOTAL-1 to 0.
- `x_o`/`y_o` are the counter registers. `req_o`, `line_start_o` and `frame_start_o` are decoded combinationally from those registers and contain no further logic.
- Per-cycle decode from the current counters:
  - active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE)
  - hs = H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC
- vs changes only at line boundaries.
- The decoded {hs, vs, ~active} bits, plus x for the test pattern, pass through a PIXEL_LATENCY-deep shift pipeline.
- Output register loads as follows:
  - vga_hsync_o = hs_d ^ ~H_SYNC_POL
  - vga_vsync_o = vs_d ^ ~V_SYNC_POL
  - vga_blank_o = blank_d
  - RGB = blank_d ? 0 : {r_i, g_i, b_i}
- Upstream may drive any value on r_i/g_i/b_i when no request is outstanding. That data is masked by blank.

## Timing
- Request at cycle t leads to output at edge t+PIXEL_LATENCY+1. Total latency from counter to pin is PIXEL_LATENCY+1 cycles for every output bit, including sync.
- Reset values while reset_i is high:
  - h_cnt = v_cnt = 0
  - pipeline blank bits = 1, sync bits = inactive
  - vga_blank_o = 1, syncs = inactive level, RGB = 0
- After reset release, the first output sync or active pixel appears PIXEL_LATENCY+1 cycles later.
- Because h_cnt=v_cnt=0 after reset, `req_o` and `frame_start_o` are high in the first cycle after release.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). The counters restart at 0,0 and no partial line is completed.
- Counter widths cover H_TOTAL ≤ 2048 and V_TOTAL ≤ 1024. A parameter set that exceeds this is a configuration error, flagged by an elaboration-time assertion.

## Configuration
- `VTG_TEST_PATTERN_EN` defined:
  - Adds input port `test_pattern_i` (1 bit, synchronous).
  - When `test_pattern_i` is high, output RGB ignores r_i/g_i/b_i and shows 8 vertical bars, each H_ACTIVE/8 pixels wide.
  - Bar colours, left to right: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - The bar index is taken from the delayed x, so bars align with sync. Blank masking still applies.
- Undefined: the port is absent and RGB always comes from r_i/g_i/b_i.

## Test plan
Small raster used throughout: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), PIXEL_LATENCY 2.
- Hold reset 5 cycles, then release. During reset: blank=1, hsync=vsync=1 (active-low idle), RGB=0. After release, req_o=1 with x=0,y=0 and frame_start_o=1 on the first cycle.
- Free-run 2 frames.
  - req_o is high for exactly 8 consecutive cycles per line on lines 0..3 and 0 on lines 4..7.
  - vga_hsync_o is low for h_cnt 10..12, delayed 3 cycles.
  - vga_vsync_o is low for lines 5..6.
  - The frame period is 128 cycles.
- Upstream returns r=x, g=y, b=0xA exactly 2 cycles after each request. Output pixel n of line m shows r=n, g=m, b=A, with blank low, 3 cycles after the request. Data driven as F during blanking never appears on the output.
- Assert reset at h_cnt=5, v_cnt=2 for 1 cycle. Outputs take reset values in the same cycle, and the next frame_start_o occurs on the first cycle after release.
- With `VTG_TEST_PATTERN_EN` defined and test_pattern_i=1, pixels 0..7 of each active line output FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000. Blanked cycles output 000.
